decode_queue_stage: RTL and testbench
=====================================

// Module: decode_queue_stage
// PURPOSE
//  Registered, parametrised decode stage for the 5-stage core. Decodes each fetched 32-bit insn into
//  a one-hot op vector plus operand fields and buffers the records in a DEPTH-entry FIFO.
//  Sits between fetch and register-read, with valid/ready on both sides and a flush from branch resolve.
//  Adds effective-register remapping (jal/setx/bex), imm sign-extension and queueing.
// PARAMETERS
//  XLEN   32  datapath width for out_imm/out_target extension
//  PC_W   32  width of carried PC
//  DEPTH  2   FIFO entries; power of 2, >=2
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        fetch presents insn
//  in_ready    out  1        stage accepts insn this cycle
//  in_insn     in   32       raw insn: op[31:27] rd[26:22] rs[21:17] rt[16:12] shamt[11:7] alu_op[6:2] imm[16:0] T[26:0]
//  in_pc       in   PC_W     PC of in_insn
//  flush       in   1        discard all queued and incoming insns
//  out_valid   out  1        head record valid
//  out_ready   in   1        consumer takes head
//  out_ops     out  NUM_OPS  one-hot op (index order in decode_pkg); all-zero = nop/unknown
//  out_rd      out  5        effective dest reg
//  out_rs      out  5        effective read port A
//  out_rt      out  5        effective read port B
//  out_shamt   out  5        shift amount
//  out_imm     out  XLEN     imm[16:0] sign-extended
//  out_target  out  XLEN     T[26:0] zero-extended
//  out_pc      out  PC_W     carried PC
//  count       out  $clog2(DEPTH+1)  occupancy
//  out_illegal out  1        only when DECODE_ILLEGAL_TRAP_EN defined
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptrs=0, out_valid=0, all out_* data=0, in_ready=1 on the following cycle.
//  - Ops: R-type (op=00000) by alu_op: add 0,sub 1,and 2,or 3,sll 4,sra 5,mul 6,div 7; other opcodes:
//    j 1,bne 2,jal 3,jr 4,addi 5,blt 6,sw 7,lw 8,setx 21,bex 22. R-type alu_op>7 or other opcode -> ops=0.
//  - Remap: jal rd=31; setx rd=30; bex rs=30; sw/bne/blt/jr out_rt=rd field; else rt field. Other fields raw.
//  - Push when in_valid&&in_ready; record visible at out_* next cycle (latency 1).
//  - in_ready = (count<DEPTH); no pass-through when full (same-cycle pop does not free a slot).
//  - Pop when out_valid&&out_ready; out_valid=(count!=0); out_* = head record, forced 0 when empty.
//  - Push+pop same cycle: count unchanged, both ptrs advance; ptrs wrap modulo DEPTH.
//  - flush: next cycle count=0, ptrs=0, out_valid=0; same-cycle push is dropped. reset > flush > push/pop.
//  - Reset mid-operation discards all entries exactly as flush.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: out_illegal=1 with record whose ops==0 (stored per entry, 0 when empty).
//  Undefined: port absent; unknown insns flow through as nop (ops=0).
// STRUCTURE
//  decode_pkg: opcode/alu_op constants, op index enum, NUM_OPS=18, decoded-record packed struct, REG_RA=31,
//  REG_RSTATUS=30. Sub-module insn_field_decode: combinational insn->record; top holds FIFO storage/ctrl.
// TESTING
//  1 add: push 0x00443000 -> next cycle out_valid=1, ops=ADD, rd=1 rs=2 rt=3.
//  2 addi: push 0x2941FFFF -> ops=ADDI, rd=5, rs=0, out_imm=0xFFFFFFFF.
//  3 jal: push 0x18000064 -> ops=JAL, rd=31, out_target=0x64; bex 0xB0000010 -> rs=30, target=0x10.
//  4 full: DEPTH=2, out_ready=0, push 3 back-to-back -> count=2, in_ready=0, 3rd not accepted; then
//    out_ready=1 -> pops in order, in_ready=1 after first pop.
//  5 flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, incoming insn absent.
//  6 unknown opcode 0xF8000000 -> ops=0; out_illegal=1 iff DECODE_ILLEGAL_TRAP_EN; reset mid-stream -> empty.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/alu_op encodings, one-hot op index
// order, special register numbers and the decoded-record layout.
package decode_pkg;

  localparam int unsigned NUM_OPS = 18;

  localparam logic [4:0] REG_RA      = 5'd31;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  typedef enum logic [4:0] {
    OPC_RTYPE = 5'd0,
    OPC_J     = 5'd1,
    OPC_BNE   = 5'd2,
    OPC_JAL   = 5'd3,
    OPC_JR    = 5'd4,
    OPC_ADDI  = 5'd5,
    OPC_BLT   = 5'd6,
    OPC_SW    = 5'd7,
    OPC_LW    = 5'd8,
    OPC_SETX  = 5'd21,
    OPC_BEX   = 5'd22
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_SLL = 5'd4,
    ALU_SRA = 5'd5,
    ALU_MUL = 5'd6,
    ALU_DIV = 5'd7
  } alu_e;

  // Bit positions inside the one-hot op vector.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLL  = 5'd4,
    OP_SRA  = 5'd5,
    OP_MUL  = 5'd6,
    OP_DIV  = 5'd7,
    OP_J    = 5'd8,
    OP_BNE  = 5'd9,
    OP_JAL  = 5'd10,
    OP_JR   = 5'd11,
    OP_ADDI = 5'd12,
    OP_BLT  = 5'd13,
    OP_SW   = 5'd14,
    OP_LW   = 5'd15,
    OP_SETX = 5'd16,
    OP_BEX  = 5'd17
  } op_idx_e;

  // Immediate and target are kept at their raw widths; extension to XLEN
  // happens when the head record is driven out.
  typedef struct packed {
    logic [NUM_OPS-1:0] ops;
    logic [4:0]         rd;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         shamt;
    logic [16:0]        imm;
    logic [26:0]        target;
  } decoded_t;

endpackage

// File: rtl/insn_field_decode.sv
// Combinational instruction decode: raw 32-bit insn -> one-hot op vector
// plus effective register fields (jal/setx/bex and store/branch remaps).
module insn_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] insn,
  output decoded_t    rec
);

  logic [4:0] opcode;
  logic [4:0] alu_op;

  assign opcode = insn[31:27];
  assign alu_op = insn[6:2];

  // Raw field extraction, then per-opcode op bit and register remapping.
  always_comb begin
    rec        = '0;
    rec.rd     = insn[26:22];
    rec.rs     = insn[21:17];
    rec.rt     = insn[16:12];
    rec.shamt  = insn[11:7];
    rec.imm    = insn[16:0];
    rec.target = insn[26:0];
    case (opcode)
      OPC_RTYPE: begin
        case (alu_op)
          ALU_ADD: rec.ops[OP_ADD] = 1'b1;
          ALU_SUB: rec.ops[OP_SUB] = 1'b1;
          ALU_AND: rec.ops[OP_AND] = 1'b1;
          ALU_OR:  rec.ops[OP_OR]  = 1'b1;
          ALU_SLL: rec.ops[OP_SLL] = 1'b1;
          ALU_SRA: rec.ops[OP_SRA] = 1'b1;
          ALU_MUL: rec.ops[OP_MUL] = 1'b1;
          ALU_DIV: rec.ops[OP_DIV] = 1'b1;
          default: rec.ops = '0;
        endcase
      end
      OPC_J:    rec.ops[OP_J] = 1'b1;
      OPC_BNE: begin
        rec.ops[OP_BNE] = 1'b1;
        rec.rt          = insn[26:22];
      end
      OPC_JAL: begin
        rec.ops[OP_JAL] = 1'b1;
        rec.rd          = REG_RA;
      end
      OPC_JR: begin
        rec.ops[OP_JR] = 1'b1;
        rec.rt         = insn[26:22];
      end
      OPC_ADDI: rec.ops[OP_ADDI] = 1'b1;
      OPC_BLT: begin
        rec.ops[OP_BLT] = 1'b1;
        rec.rt          = insn[26:22];
      end
      OPC_SW: begin
        rec.ops[OP_SW] = 1'b1;
        rec.rt         = insn[26:22];
      end
      OPC_LW:   rec.ops[OP_LW] = 1'b1;
      OPC_SETX: begin
        rec.ops[OP_SETX] = 1'b1;
        rec.rd           = REG_RSTATUS;
      end
      OPC_BEX: begin
        rec.ops[OP_BEX] = 1'b1;
        rec.rs          = REG_RSTATUS;
      end
      default: rec.ops = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage with a DEPTH-entry record FIFO between fetch and register
// read. Valid/ready on both sides; flush drops queued and incoming insns.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds out_illegal (ops==0 marker).
// Assumes XLEN > 27 so imm/target extension fields are non-empty.
module decode_queue_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_insn,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_OPS-1:0]           out_ops,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_rs,
  output logic [4:0]                   out_rt,
  output logic [4:0]                   out_shamt,
  output logic [XLEN-1:0]              out_imm,
  output logic [XLEN-1:0]              out_target,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                         out_illegal
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  decoded_t         dec;
  decoded_t         rec_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem  [DEPTH];
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             ill_mem [DEPTH];
`endif
  decoded_t         head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  insn_field_decode u_decode (
    .insn (in_insn),
    .rec  (dec)
  );

  // A pop in the same cycle never frees a slot for a push when full.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush && !reset;
  assign pop       = out_valid && out_ready && !flush && !reset;
  assign head      = rec_mem[rd_ptr];

  // Pointer and occupancy control; reset and flush both empty the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents of unoccupied slots are never observed.
  always_ff @(posedge clock) begin
    if (push) begin
      rec_mem[wr_ptr] <= dec;
      pc_mem[wr_ptr]  <= in_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ill_mem[wr_ptr] <= (dec.ops == '0);
`endif
    end
  end

  // Head record drive with extension, forced to zero while empty.
  always_comb begin
    out_ops    = '0;
    out_rd     = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_shamt  = '0;
    out_imm    = '0;
    out_target = '0;
    out_pc     = '0;
    if (out_valid) begin
      out_ops    = head.ops;
      out_rd     = head.rd;
      out_rs     = head.rs;
      out_rt     = head.rt;
      out_shamt  = head.shamt;
      out_imm    = {{(XLEN-17){head.imm[16]}}, head.imm};
      out_target = {{(XLEN-27){1'b0}}, head.target};
      out_pc     = pc_mem[rd_ptr];
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = out_valid && ill_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage: driver queues hand-computed
// expected records, monitor compares each head record as it is popped.
module tb_decode_queue_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_insn = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_ops;
  logic [4:0]  out_rd, out_rs, out_rt, out_shamt;
  logic [31:0] out_imm, out_target, out_pc;
  logic [1:0]  count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  decode_queue_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_insn    (in_insn),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ops    (out_ops),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_shamt  (out_shamt),
    .out_imm    (out_imm),
    .out_target (out_target),
    .out_pc     (out_pc),
    .count      (count)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] ops;
    logic [4:0]  rd, rs, rt, shamt;
    logic [31:0] imm, target, pc;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] vec_i [10];
  exp_t        vec_e [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [17:0] ops, input logic [4:0] rd, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] sh, input logic [31:0] imm,
                              input logic [31:0] tgt, input logic [31:0] pc, input logic ill);
    exp_t e;
    e.ops = ops; e.rd = rd; e.rs = rs; e.rt = rt; e.shamt = sh;
    e.imm = imm; e.target = tgt; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  // Monitor: compare the head record on every cycle it is being consumed.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ops",    32'(out_ops),   32'(e.ops));
          chk("rd",     32'(out_rd),    32'(e.rd));
          chk("rs",     32'(out_rs),    32'(e.rs));
          chk("rt",     32'(out_rt),    32'(e.rt));
          chk("shamt",  32'(out_shamt), 32'(e.shamt));
          chk("imm",    out_imm,        e.imm);
          chk("target", out_target,     e.target);
          chk("pc",     out_pc,         e.pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
          chk("illegal", 32'(out_illegal), 32'(e.ill));
`endif
        end
      end
    end
  end

  task automatic send(input int idx, input logic acc);
    in_valid = 1'b1;
    in_insn  = vec_i[idx];
    in_pc    = vec_e[idx].pc;
    @(negedge clock);
    chk("in_ready", 32'(in_ready), 32'(acc));
    if (in_ready && !flush) exp_q.push_back(vec_e[idx]);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_i[0] = 32'h0044_3000;
    vec_e[0] = mk(18'h00001, 5'd1,  5'd2,  5'd3,  5'd0,  32'h0000_3000, 32'h0044_3000, 32'h100, 1'b0);
    vec_i[1] = 32'h2941_FFFF;
    vec_e[1] = mk(18'h01000, 5'd5,  5'd0,  5'd31, 5'd31, 32'hFFFF_FFFF, 32'h0141_FFFF, 32'h104, 1'b0);
    vec_i[2] = 32'h1800_0064;
    vec_e[2] = mk(18'h00400, 5'd31, 5'd0,  5'd0,  5'd0,  32'h0000_0064, 32'h0000_0064, 32'h108, 1'b0);
    vec_i[3] = 32'hB000_0010;
    vec_e[3] = mk(18'h20000, 5'd0,  5'd30, 5'd0,  5'd0,  32'h0000_0010, 32'h0000_0010, 32'h10C, 1'b0);
    vec_i[4] = 32'h390C_0008;
    vec_e[4] = mk(18'h04000, 5'd4,  5'd6,  5'd4,  5'd0,  32'h0000_0008, 32'h010C_0008, 32'h110, 1'b0);
    vec_i[5] = 32'hA800_1234;
    vec_e[5] = mk(18'h10000, 5'd30, 5'd0,  5'd1,  5'd4,  32'h0000_1234, 32'h0000_1234, 32'h114, 1'b0);
    vec_i[6] = 32'h01D0_9194;
    vec_e[6] = mk(18'h00020, 5'd7,  5'd8,  5'd9,  5'd3,  32'h0000_9194, 32'h01D0_9194, 32'h118, 1'b0);
    vec_i[7] = 32'hF800_0000;
    vec_e[7] = mk(18'h00000, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'h11C, 1'b1);
    vec_i[8] = 32'h0000_0020;
    vec_e[8] = mk(18'h00000, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0000_0020, 32'h0000_0020, 32'h120, 1'b1);
    vec_i[9] = 32'h4087_0004;
    vec_e[9] = mk(18'h08000, 5'd2,  5'd3,  5'd16, 5'd0,  32'hFFFF_0004, 32'h0087_0004, 32'h124, 1'b0);

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_ops",   32'(out_ops),   32'd0);
    chk("rst_out_imm",   out_imm,        32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    @(posedge clock);
    #1;

    // Streaming: every vector back-to-back with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(i, 1'b1);
    drain();
    chk("empty_ops",    32'(out_ops), 32'd0);
    chk("empty_target", out_target,   32'd0);

    // Full: two accepted, third refused; pops restore in_ready
    out_ready = 1'b0;
    send(0, 1'b1);
    send(1, 1'b1);
    send(2, 1'b0);
    @(negedge clock);
    chk("full_count",    32'(count),    32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("pop1_in_ready", 32'(in_ready), 32'd1);
    chk("pop1_count",    32'(count),    32'd1);
    drain();

    // Flush with two queued and an incoming insn
    out_ready = 1'b0;
    send(3, 1'b1);
    send(4, 1'b1);
    in_valid = 1'b1;
    in_insn  = vec_i[5];
    in_pc    = vec_e[5].pc;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_ops",   32'(out_ops),   32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Reset mid-stream empties the queue, then operation resumes
    out_ready = 1'b0;
    send(6, 1'b1);
    send(7, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("mrst_count",     32'(count),     32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    send(7, 1'b1);
    send(8, 1'b1);
    send(9, 1'b1);
    drain();
    @(negedge clock);
    chk("final_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
